// File: rtl/comb_dmem_ctrl.sv
// Shared data-memory controller: round-robin combinational arbitration of NCORES ports onto one
// single-ported word RAM, per-core read hold registers and LR/SC reservations.
module comb_dmem_ctrl #(
  parameter int unsigned NCORES     = 2,
  parameter int unsigned DMEM_ADDRW = 12
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [NCORES-1:0]            re_packed_i,
  input  logic [NCORES-1:0]            we_packed_i,
  input  logic [DMEM_ADDRW*NCORES-1:0] addr_packed_i,
  input  logic [32*NCORES-1:0]         wdata_packed_i,
  input  logic [4*NCORES-1:0]          wstrb_packed_i,
  input  logic [NCORES-1:0]            is_lr_packed_i,
  input  logic [NCORES-1:0]            is_sc_packed_i,
  output logic [32*NCORES-1:0]         rdata_packed_o,
  output logic [NCORES-1:0]            stall_packed_o
);

  localparam int unsigned PW    = (NCORES > 1) ? $clog2(NCORES) : 1;
  localparam int unsigned DEPTH = 2 ** DMEM_ADDRW;

  logic [NCORES-1:0]     req;
  logic [NCORES-1:0]     grant;
  logic                  any_grant;
  logic [PW-1:0]         gnt_idx;
  logic [PW-1:0]         ptr_q, ptr_d;

  logic [DMEM_ADDRW-1:0] g_addr;
  logic [31:0]           g_wdata;
  logic [3:0]            g_wstrb;
  logic                  g_re, g_we, g_lr, g_sc;
  logic                  rd_fire, lr_fire, wr_fire, sc_fire, sc_ok, do_write;

  logic [31:0]           mem [DEPTH];
  logic [31:0]           ram_q;

  logic [NCORES-1:0]     res_valid_q;
  logic [DMEM_ADDRW-1:0] res_addr_q [NCORES];

  logic                  pend_valid_q;
  logic                  pend_sc_q;
  logic                  sc_fail_q;
  logic [PW-1:0]         pend_core_q;
  logic [31:0]           pend_data;
  logic [31:0]           hold_q [NCORES];

  assign req = re_packed_i | we_packed_i;

  // Scan from the priority pointer; first requester wins.
  always_comb begin
    grant     = '0;
    gnt_idx   = '0;
    any_grant = 1'b0;
    for (int unsigned k = 0; k < NCORES; k++) begin
      int unsigned idx;
      idx = (int'(ptr_q) + k) % NCORES;
      if (!any_grant && req[idx]) begin
        any_grant  = 1'b1;
        grant[idx] = 1'b1;
        gnt_idx    = PW'(idx);
      end
    end
  end

  assign stall_packed_o = req & ~grant;

  always_comb begin
    ptr_d = ptr_q;
    if (any_grant) ptr_d = PW'((int'(gnt_idx) + 1) % NCORES);
  end

  assign g_addr  = addr_packed_i[DMEM_ADDRW*gnt_idx +: DMEM_ADDRW];
  assign g_wdata = wdata_packed_i[32*gnt_idx +: 32];
  assign g_wstrb = wstrb_packed_i[4*gnt_idx +: 4];
  assign g_re    = re_packed_i[gnt_idx];
  assign g_we    = we_packed_i[gnt_idx];
  assign g_lr    = is_lr_packed_i[gnt_idx];
  assign g_sc    = is_sc_packed_i[gnt_idx];

  // A core asserting both re and we is treated as a writer.
  assign rd_fire  = any_grant & g_re & ~g_we;
  assign lr_fire  = rd_fire & g_lr;
  assign wr_fire  = any_grant & g_we;
  assign sc_fire  = wr_fire & g_sc;
  assign sc_ok    = res_valid_q[gnt_idx] & (res_addr_q[gnt_idx] == g_addr);
  assign do_write = wr_fire & (~g_sc | sc_ok);

  always_ff @(posedge clk_i) begin
    if (do_write) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (g_wstrb[b]) mem[g_addr][8*b +: 8] <= g_wdata[8*b +: 8];
      end
    end
    if (rd_fire) ram_q <= mem[g_addr];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // Any performed write kills matching reservations, the writer's own included.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      res_valid_q <= '0;
      for (int unsigned i = 0; i < NCORES; i++) res_addr_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NCORES; i++) begin
        if (do_write && (res_addr_q[i] == g_addr)) res_valid_q[i] <= 1'b0;
      end
      if (lr_fire) begin
        res_valid_q[gnt_idx] <= 1'b1;
        res_addr_q[gnt_idx]  <= g_addr;
      end
      if (sc_fire) res_valid_q[gnt_idx] <= 1'b0;
    end
  end

  // The RAM output is only valid for one cycle, so it is forwarded to the owning core and
  // copied into that core's hold register at the following edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_valid_q <= 1'b0;
      pend_sc_q    <= 1'b0;
      sc_fail_q    <= 1'b0;
      pend_core_q  <= '0;
    end else begin
      pend_valid_q <= rd_fire | sc_fire;
      pend_sc_q    <= sc_fire;
      sc_fail_q    <= ~sc_ok;
      pend_core_q  <= gnt_idx;
    end
  end

  assign pend_data = pend_sc_q ? {31'd0, sc_fail_q} : ram_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < NCORES; i++) hold_q[i] <= '0;
    end else if (pend_valid_q) begin
      hold_q[pend_core_q] <= pend_data;
    end
  end

  always_comb begin
    rdata_packed_o = '0;
    for (int unsigned i = 0; i < NCORES; i++) begin
      if (pend_valid_q && (pend_core_q == PW'(i))) begin
        rdata_packed_o[32*i +: 32] = pend_data;
      end else begin
        rdata_packed_o[32*i +: 32] = hold_q[i];
      end
    end
  end

endmodule

// File: tb/tb_comb_dmem_ctrl.sv
// Directed bench for comb_dmem_ctrl with NCORES=2, DMEM_ADDRW=12.
module tb_comb_dmem_ctrl;

  logic        clk;
  logic        rst_n;
  logic [1:0]  re, we, lr, sc;
  logic [23:0] addr;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic [63:0] rdata;
  logic [1:0]  stall;

  int checks = 0;
  int errors = 0;

  comb_dmem_ctrl #(
    .NCORES    (2),
    .DMEM_ADDRW(12)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .re_packed_i   (re),
    .we_packed_i   (we),
    .addr_packed_i (addr),
    .wdata_packed_i(wdata),
    .wstrb_packed_i(wstrb),
    .is_lr_packed_i(lr),
    .is_sc_packed_i(sc),
    .rdata_packed_o(rdata),
    .stall_packed_o(stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic set_req(input int c, input bit r, input bit w, input logic [11:0] a,
                         input logic [31:0] d, input logic [3:0] s, input bit l, input bit x);
    re[c]            = r;
    we[c]            = w;
    lr[c]            = l;
    sc[c]            = x;
    addr[12*c +: 12] = a;
    wdata[32*c +: 32] = d;
    wstrb[4*c +: 4]  = s;
  endtask

  task automatic clr_req(input int c);
    set_req(c, 1'b0, 1'b0, 12'h0, 32'h0, 4'h0, 1'b0, 1'b0);
  endtask

  // One uncontended access by core c; returns just after the edge that ends its grant cycle.
  task automatic op(input string tag, input int c, input bit r, input bit w, input logic [11:0] a,
                    input logic [31:0] d, input logic [3:0] s, input bit l, input bit x);
    @(posedge clk);
    #1;
    set_req(c, r, w, a, d, s, l, x);
    @(negedge clk);
    check_eq({tag, "_stall"}, {31'd0, stall[c]}, 32'd0);
    @(posedge clk);
    #1;
    clr_req(c);
  endtask

  task automatic rd_check(input string tag, input int c, input logic [31:0] exp);
    @(negedge clk);
    check_eq(tag, rdata[32*c +: 32], exp);
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_eq("rst_rdata0", rdata[31:0], 32'd0);
    check_eq("rst_rdata1", rdata[63:32], 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    clr_req(0);
    clr_req(1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("reset_rdata0", rdata[31:0], 32'd0);
    check_eq("reset_rdata1", rdata[63:32], 32'd0);
    check_eq("reset_stall", {30'd0, stall}, 32'd0);
    rst_n = 1'b1;

    // Single-core write then read.
    op("wr010", 0, 0, 1, 12'h010, 32'hDEADBEEF, 4'hF, 0, 0);
    op("rd010", 0, 1, 0, 12'h010, 32'h0, 4'h0, 0, 0);
    rd_check("rd010_data", 0, 32'hDEADBEEF);
    check_eq("rd010_core1_untouched", rdata[63:32], 32'd0);

    // Byte strobes, including an all-zero strobe.
    op("wr020", 0, 0, 1, 12'h020, 32'h11223344, 4'hF, 0, 0);
    op("wr020_strb", 0, 0, 1, 12'h020, 32'hAABBCCDD, 4'b0101, 0, 0);
    op("wr020_zero", 0, 0, 1, 12'h020, 32'h55555555, 4'b0000, 0, 0);
    op("rd020", 0, 1, 0, 12'h020, 32'h0, 4'h0, 0, 0);
    rd_check("rd020_data", 0, 32'h11BB33DD);

    // Contention from p=0: core0 first, then core1 alone.
    pulse_reset();
    @(posedge clk);
    #1;
    set_req(0, 1, 0, 12'h010, 32'h0, 4'h0, 0, 0);
    set_req(1, 1, 0, 12'h020, 32'h0, 4'h0, 0, 0);
    @(negedge clk);
    check_eq("cont_stall_c1", {30'd0, stall}, 32'b10);
    @(posedge clk);
    #1;
    clr_req(0);
    @(negedge clk);
    check_eq("cont_stall_c2", {30'd0, stall}, 32'b00);
    check_eq("cont_rd0", rdata[31:0], 32'hDEADBEEF);
    @(posedge clk);
    #1;
    clr_req(1);
    @(negedge clk);
    check_eq("cont_rd1", rdata[63:32], 32'h11BB33DD);

    // Persistent requests from both cores alternate 0,1,0,1.
    @(posedge clk);
    #1;
    set_req(0, 1, 0, 12'h010, 32'h0, 4'h0, 0, 0);
    set_req(1, 1, 0, 12'h020, 32'h0, 4'h0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_eq($sformatf("alt_stall_%0d", k), {30'd0, stall}, (k % 2 == 0) ? 32'b10 : 32'b01);
    end
    @(posedge clk);
    #1;
    clr_req(0);
    clr_req(1);

    // LR/SC success, then a second SC fails without writing.
    op("wr040", 0, 0, 1, 12'h040, 32'h12345678, 4'hF, 0, 0);
    op("lr040", 0, 1, 0, 12'h040, 32'h0, 4'h0, 1, 0);
    rd_check("lr040_data", 0, 32'h12345678);
    op("sc040", 0, 0, 1, 12'h040, 32'd5, 4'hF, 0, 1);
    rd_check("sc040_status", 0, 32'd0);
    op("rd040a", 0, 1, 0, 12'h040, 32'h0, 4'h0, 0, 0);
    rd_check("rd040a_data", 0, 32'd5);
    op("sc040b", 0, 0, 1, 12'h040, 32'd6, 4'hF, 0, 1);
    rd_check("sc040b_status", 0, 32'd1);
    op("wr060", 0, 0, 1, 12'h060, 32'hAA, 4'hF, 0, 0);
    rd_check("wr060_hold", 0, 32'd1);
    op("rd040b", 0, 1, 0, 12'h040, 32'h0, 4'h0, 0, 0);
    rd_check("rd040b_data", 0, 32'd5);

    // Reservation killed by another core's plain write.
    op("lr040k", 0, 1, 0, 12'h040, 32'h0, 4'h0, 1, 0);
    rd_check("lr040k_data", 0, 32'd5);
    op("wr040k", 1, 0, 1, 12'h040, 32'd9, 4'hF, 0, 0);
    op("sc040k", 0, 0, 1, 12'h040, 32'd7, 4'hF, 0, 1);
    rd_check("sc040k_status", 0, 32'd1);
    op("rd040k", 0, 1, 0, 12'h040, 32'h0, 4'h0, 0, 0);
    rd_check("rd040k_data", 0, 32'd9);

    // Reset between LR and SC drops the reservation.
    op("wr050", 1, 0, 1, 12'h050, 32'hCAFEF00D, 4'hF, 0, 0);
    op("lr050", 1, 1, 0, 12'h050, 32'h0, 4'h0, 1, 0);
    rd_check("lr050_data", 1, 32'hCAFEF00D);
    pulse_reset();
    op("sc050", 1, 0, 1, 12'h050, 32'h00000BAD, 4'hF, 0, 1);
    rd_check("sc050_status", 1, 32'd1);
    op("rd050", 1, 1, 0, 12'h050, 32'h0, 4'h0, 0, 0);
    rd_check("rd050_data", 1, 32'hCAFEF00D);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
